// File: rtl/key_search_controller.sv
// Drives one decryption core through candidate keys and scans the decrypted
// message for text made only of lowercase ASCII letters and spaces.
module key_search_controller #(
    parameter int KEY_WIDTH  = 10,
    parameter int MSG_LEN    = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int KEY_LAST   = 2**KEY_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  core_restart,
    output logic                  core_start,
    output logic [KEY_WIDTH-1:0]  core_key,
    input  logic                  core_done,
    output logic [ADDR_WIDTH-1:0] d_rd_addr,
    input  logic [7:0]            d_rd_q,
    output logic                  busy,
    output logic                  found,
    output logic                  fail,
    output logic [KEY_WIDTH-1:0]  found_key
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [KEY_WIDTH-1:0] KEY_LAST_V = KEY_WIDTH'(KEY_LAST);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_ARM_WAIT,
        S_START,
        S_WAIT_CORE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_CHECK,
        S_NEXT_KEY,
        S_FOUND,
        S_FAIL
    } state_t;

    state_t                 state, state_nxt;
    logic [KEY_WIDTH-1:0]   key_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic                   found_nxt, fail_nxt;
    logic [KEY_WIDTH-1:0]   found_key_nxt;

    function automatic logic is_text_byte(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    assign d_rd_addr = ADDR_WIDTH'(idx);

    always_comb begin
        state_nxt     = state;
        key_nxt       = core_key;
        idx_nxt       = idx;
        found_nxt     = found;
        fail_nxt      = fail;
        found_key_nxt = found_key;
        core_restart  = 1'b0;
        core_start    = 1'b0;
        busy          = 1'b1;

        case (state)
            // FOUND and FAIL hold their result but accept a new search directly
            S_IDLE, S_FOUND, S_FAIL: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt     = S_ARM;
                    key_nxt       = '0;
                    found_nxt     = 1'b0;
                    fail_nxt      = 1'b0;
                    found_key_nxt = '0;
                end
            end
            S_ARM: begin
                core_restart = 1'b1;
                state_nxt    = S_ARM_WAIT;
            end
            S_ARM_WAIT: begin
                if (!core_done) state_nxt = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                // start is released in the same cycle done is seen
                if (core_done) begin
                    idx_nxt   = '0;
                    state_nxt = S_RD_ADDR;
                end else begin
                    core_start = 1'b1;
                end
            end
            S_RD_ADDR: state_nxt = S_RD_WAIT;
            S_RD_WAIT: state_nxt = S_CHECK;
            S_CHECK: begin
                if (!is_text_byte(d_rd_q)) begin
                    state_nxt = S_NEXT_KEY;
                end else if (idx == IDX_LAST) begin
                    state_nxt     = S_FOUND;
                    found_nxt     = 1'b1;
                    found_key_nxt = core_key;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_RD_ADDR;
                end
            end
            S_NEXT_KEY: begin
                if (core_key == KEY_LAST_V) begin
                    state_nxt = S_FAIL;
                    fail_nxt  = 1'b1;
                end else begin
                    key_nxt   = core_key + 1'b1;
                    state_nxt = S_ARM;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            core_key  <= '0;
            idx       <= '0;
            found     <= 1'b0;
            fail      <= 1'b0;
            found_key <= '0;
        end else begin
            state     <= state_nxt;
            core_key  <= key_nxt;
            idx       <= idx_nxt;
            found     <= found_nxt;
            fail      <= fail_nxt;
            found_key <= found_key_nxt;
        end
    end

endmodule

// File: tb/tb_key_search_controller.sv
// Directed bench for key_search_controller with a behavioural decryption core
// and a two-cycle-latency D-memory read port.
module tb_key_search_controller;

    localparam int KW       = 3;
    localparam int ML       = 32;
    localparam int AW       = 5;
    localparam int CORE_LAT = 4;
    localparam int M_KEY3   = 0;
    localparam int M_ALL    = 1;
    localparam int M_BOUND  = 2;
    localparam int M_NONE   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          core_restart, core_start, core_done;
    logic [KW-1:0] core_key, found_key;
    logic [AW-1:0] d_rd_addr, addr_q;
    logic [7:0]    d_rd_q;
    logic          busy, found, fail;

    int            mode = M_ALL;
    logic [7:0]    bnd_byte = 8'h20;
    int            n_vec = 0;
    int            n_miss = 0;

    key_search_controller #(
        .KEY_WIDTH (KW),
        .MSG_LEN   (ML),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_restart(core_restart),
        .core_start  (core_start),
        .core_key    (core_key),
        .core_done   (core_done),
        .d_rd_addr   (d_rd_addr),
        .d_rd_q      (d_rd_q),
        .busy        (busy),
        .found       (found),
        .fail        (fail),
        .found_key   (found_key)
    );

    always #5 clk = ~clk;

    // Message content as a function of scenario, key and byte index
    function automatic logic [7:0] msg_byte(input int m, input int key, input int idx);
        logic [7:0] txt;
        txt = (idx % 5 == 4) ? 8'h20 : 8'h61 + 8'(idx % 26);
        case (m)
            M_KEY3:  return (key != 3 && idx == key * 10) ? 8'h41 : txt;
            M_ALL:   return txt;
            M_BOUND: begin
                if (key != 0) return txt;
                if (idx == ML - 1) return bnd_byte;
                case (idx % 3)
                    0:       return 8'h20;
                    1:       return 8'h61;
                    default: return 8'h7A;
                endcase
            end
            default: return 8'h41;
        endcase
    endfunction

    // Behavioural core and D-memory read port
    int lat_cnt;
    always @(posedge clk) begin
        if (reset || core_restart) begin
            core_done <= 1'b0;
            lat_cnt   <= 0;
        end else if (core_start && !core_done) begin
            if (lat_cnt == CORE_LAT - 1) core_done <= 1'b1;
            lat_cnt <= lat_cnt + 1;
        end
        addr_q <= d_rd_addr;
        d_rd_q <= msg_byte(mode, int'(core_key), int'(addr_q));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            restart_cnt, restart_rise, done_cyc, found_cyc;
    int            addr1_cyc = -1;
    int            v_start_done, v_rst_start, v_ff, v_wrap;
    int            deltas[$];
    bit            seen_done, prev_done, prev_rst, prev_found, prev_busy;
    logic [KW-1:0] prev_key = '0;

    always @(negedge clk) begin
        if (core_done === 1'b1 && !prev_done) begin
            done_cyc  = cyc;
            addr1_cyc = -1;
            seen_done = 1'b1;
        end
        if (d_rd_addr == AW'(1) && addr1_cyc < 0 && cyc > done_cyc) addr1_cyc = cyc;
        if (core_restart) begin
            restart_cnt++;
            if (!prev_rst) restart_rise++;
            if (seen_done) deltas.push_back(cyc - done_cyc);
            seen_done = 1'b0;
        end
        if (found && !prev_found) found_cyc = cyc;
        if (found || fail || reset) seen_done = 1'b0;
        if (core_start && core_done === 1'b1) v_start_done++;
        if (core_restart && core_start) v_rst_start++;
        if (found && fail) v_ff++;
        if (busy && prev_busy && core_key < prev_key) v_wrap++;
        prev_done  = (core_done === 1'b1);
        prev_rst   = core_restart;
        prev_found = found;
        prev_busy  = busy;
        prev_key   = core_key;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int delta_at(input int i);
        return (i < deltas.size()) ? deltas[i] : -1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(found || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("search_done_in_budget", (n < budget) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    logic [7:0] bnd_tbl [4] = '{8'h20, 8'h1F, 8'h60, 8'h7B};
    int         bnd_exp [4] = '{0, 1, 1, 1};

    initial begin
        int r0, q0, n;

        repeat (3) @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_found", int'(found), 0);
        check_val("rst_fail", int'(fail), 0);
        check_val("rst_found_key", int'(found_key), 0);
        check_val("rst_core_key", int'(core_key), 0);
        check_val("rst_core_start", int'(core_start), 0);
        check_val("rst_core_restart", int'(core_restart), 0);
        check_val("rst_rd_addr", int'(d_rd_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Only key 3 decrypts to text; start re-pulsed while waiting on the core
        mode = M_KEY3;
        r0 = restart_cnt;
        n  = restart_rise;
        q0 = deltas.size();
        pulse_start();
        check_val("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 100 && !core_start; i++) @(negedge clk);
        @(negedge clk);
        pulse_start();
        wait_end(5000);
        check_val("k3_found", int'(found), 1);
        check_val("k3_found_key", int'(found_key), 3);
        check_val("k3_fail", int'(fail), 0);
        check_val("k3_busy", int'(busy), 0);
        check_val("k3_restart_cycles", restart_cnt - r0, 4);
        check_val("k3_restart_pulses", restart_rise - n, 4);
        check_val("k3_key0_abort_idx0", delta_at(q0), 5);
        check_val("k3_key1_abort_idx10", delta_at(q0 + 1), 35);
        check_val("k3_key2_abort_idx20", delta_at(q0 + 2), 65);

        // Key 0 is valid: timing from done to first read and to found
        mode = M_ALL;
        r0 = restart_cnt;
        pulse_start();
        wait_end(5000);
        check_val("all_found_key", int'(found_key), 0);
        check_val("all_found", int'(found), 1);
        check_val("all_restarts", restart_cnt - r0, 1);
        check_val("all_addr1_after_done", addr1_cyc - done_cyc, 4);
        check_val("all_found_after_done", found_cyc - done_cyc, 97);

        // Boundary bytes placed at the last index of key 0
        mode = M_BOUND;
        for (int i = 0; i < 4; i++) begin
            bnd_byte = bnd_tbl[i];
            r0 = restart_cnt;
            q0 = deltas.size();
            pulse_start();
            wait_end(5000);
            check_val($sformatf("bnd_%02h_found_key", bnd_tbl[i]), int'(found_key), bnd_exp[i]);
            check_val($sformatf("bnd_%02h_restarts", bnd_tbl[i]), restart_cnt - r0, bnd_exp[i] + 1);
            if (bnd_exp[i] == 1)
                check_val($sformatf("bnd_%02h_32_reads", bnd_tbl[i]), delta_at(q0), 98);
        end

        // Reset asserted while checking the first byte
        mode = M_ALL;
        pulse_start();
        for (int i = 0; i < 100 && core_done !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_val("pre_rst_busy", int'(busy), 1);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_core_start", int'(core_start), 0);
        check_val("mid_rst_found", int'(found), 0);
        check_val("mid_rst_core_key", int'(core_key), 0);
        @(negedge clk);
        reset = 1'b0;
        r0 = restart_cnt;
        repeat (10) @(negedge clk);
        check_val("post_rst_idle_busy", int'(busy), 0);
        check_val("post_rst_no_restart", restart_cnt - r0, 0);
        check_val("post_rst_found", int'(found), 0);

        // No key yields text: fail after the last key with no wrap
        mode = M_NONE;
        r0 = restart_cnt;
        pulse_start();
        wait_end(5000);
        check_val("none_fail", int'(fail), 1);
        check_val("none_found", int'(found), 0);
        check_val("none_found_key", int'(found_key), 0);
        check_val("none_last_key", int'(core_key), 7);
        check_val("none_restarts", restart_cnt - r0, 8);
        check_val("none_busy", int'(busy), 0);

        check_val("start_while_done", v_start_done, 0);
        check_val("restart_with_start", v_rst_start, 0);
        check_val("found_and_fail", v_ff, 0);
        check_val("key_wrap", v_wrap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_search_controller.md
Name: key_search_controller

Overview:
- Initiator-side counterpart of the decryption core's start/done responder interface.
- Sweeps candidate keys: arms the core, issues start with a key, waits for done, then reads back the decrypted-message memory (D memory) over its read port.
- Declares the key found if every byte is lowercase ASCII or space; otherwise advances to the next key.
- Sits at top level, between the switches/LED/HEX logic and one decryption core instance.

Parameters:
- KEY_WIDTH, 10, width of candidate key driven to the core.
- MSG_LEN, 32, number of D-memory bytes checked per key.
- ADDR_WIDTH, 5, D-memory address width; MSG_LEN <= 2**ADDR_WIDTH.
- KEY_LAST, 2**KEY_WIDTH-1, last key tried before declaring failure.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a search from key 0; sampled only in IDLE.
- core_restart  out  1  one-cycle pulse returning the core to its idle state.
- core_start  out  1  start request to the core, held as a level.
- core_key  out  KEY_WIDTH  key presented to the core; stable from ARM until the key is retired.
- core_done  in  1  level from the core; high once decryption completes, until restart.
- d_rd_addr  out  ADDR_WIDTH  D-memory read address.
- d_rd_q  in  8  D-memory read data, valid on the second rising edge after the address is driven.
- busy  out  1  high in every state except IDLE, FOUND and FAIL.
- found  out  1  sticky; a valid key was located.
- fail  out  1  sticky; all keys 0..KEY_LAST were rejected.
- found_key  out  KEY_WIDTH  key that produced the valid message; 0 unless found.

Behaviour:
- Reset values: state=IDLE; core_restart=0, core_start=0, core_key=0, d_rd_addr=0, busy=0, found=0, fail=0, found_key=0.
- States:
  - IDLE: on start=1, clear found, fail and found_key; set key=0; go to ARM.
  - ARM: core_restart=1 for exactly one cycle; go to ARM_WAIT.
  - ARM_WAIT: remain until core_done=0, then go to START. This guards against a stale done from the previous key.
  - START: core_start=1; go to WAIT_CORE.
  - WAIT_CORE: hold core_start=1 until core_done=1. Then drop core_start, set idx=0, go to RD_ADDR.
  - RD_ADDR: drive d_rd_addr=idx; go to RD_WAIT.
  - RD_WAIT: hold the address; go to CHECK.
  - CHECK: sample d_rd_q.
    - Byte is valid iff 8'h61 <= byte <= 8'h7A, or byte == 8'h20.
    - Invalid byte: go to NEXT_KEY immediately (early abort).
    - Valid and idx == MSG_LEN-1: go to FOUND.
    - Otherwise: idx++ and return to RD_ADDR.
  - NEXT_KEY: if key == KEY_LAST, go to FAIL. Otherwise key++ and go to ARM. No wrap-around ever occurs.
  - FOUND: found=1, found_key=key, busy=0; hold. A new start returns to the IDLE-accept path on the next cycle.
  - FAIL: fail=1, busy=0; hold. Same start handling as FOUND.
- Latency:
  - Read cost is 3 cycles per checked byte.
  - Overhead outside core time is 3 cycles per key: ARM, ARM_WAIT with core_done already low, START.
  - A fully valid message adds MSG_LEN*3 cycles before found rises.
- Handshake rules:
  - core_start never asserts while core_done=1.
  - core_restart never coincides with core_start.
  - start is ignored while busy=1.
- idx is $clog2(MSG_LEN) bits wide and never exceeds MSG_LEN-1.
- Reset asserted mid-search: all outputs return to reset values asynchronously. The search does not resume after reset deasserts.
- found and fail are never both high.

Test Plan:
- Core model decrypts to valid text only for key 3; pulse start → keys 0,1,2 are rejected and found=1 with found_key=3, fail=0, busy=0. Each rejected key shows exactly one core_restart pulse.
- Key 0 produces an all-valid message; check the sequence "start → found" and the timing → first d_rd_addr follows core_done by 1 cycle, and found rises 96 cycles after the first read address.
- Boundary bytes: 0x20, 0x61 and 0x7A accepted; 0x1F, 0x60 and 0x7B each rejected when placed at idx 31 → key is retired only after 32 reads.
- Invalid byte at idx 0 → exactly one read for that key, then NEXT_KEY.
- KEY_WIDTH=3 and no valid key → fail=1 after key 7, found=0, found_key=0, core_key never wraps to 0.
- Start re-pulsed during WAIT_CORE is ignored. Reset asserted during CHECK → busy, core_start and found go to 0 immediately, and the state stays IDLE after reset is released.
